// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream in, framed payload out: the link between the UART
// receiver side, the frame controller and the payload consumer.
interface uart_rx_frame_ctrl_if;
  logic [7:0] iData;
  logic       iValid;
  logic       iRdEn;
  logic [7:0] oData;
  logic       oDataValid;
  logic       oFrameReady;
  logic [7:0] oLen;
  logic       oErrLen;
  logic       oErrCsum;
  logic       oErrTimeout;
  logic       oDrop;
  logic       oBusy;

  modport master (
    output iData, iValid, iRdEn,
    input  oData, oDataValid, oFrameReady, oLen,
    input  oErrLen, oErrCsum, oErrTimeout, oDrop, oBusy
  );

  modport slave (
    input  iData, iValid, iRdEn,
    output oData, oDataValid, oFrameReady, oLen,
    output oErrLen, oErrCsum, oErrTimeout, oDrop, oBusy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frames SYNC/LEN/PAYLOAD/CSUM packets from the UART byte strobe,
// buffers the payload and hands it out one byte per read request.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 1000
) (
  input logic            clk,
  input logic            reset,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int         TW   = $clog2(TIMEOUT);
  localparam int         AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAXL = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, LEN, PAYLOAD, CSUM, READY
  } state_t;

  state_t        state, state_d;
  logic [7:0]    len, sum, cnt, rdptr;
  logic [7:0]    mem [MAX_LEN];
  logic [TW-1:0] tcnt;

  logic active, expire, len_ok, csum_ok;
  logic rd, last_rd, wr;
  logic err_len_d, err_csum_d, err_to_d, drop_d;

  assign active  = (state == LEN) || (state == PAYLOAD) ||
                   (state == CSUM);
  assign expire  = active && !bus.iValid &&
                   (tcnt == TW'(TIMEOUT - 1));
  assign len_ok  = (bus.iData != 8'd0) && (bus.iData <= MAXL);
  assign csum_ok = (bus.iData == sum);
  assign rd      = (state == READY) && bus.iRdEn;
  assign last_rd = rd && (rdptr == len - 8'd1);
  assign wr      = (state == PAYLOAD) && bus.iValid;
  assign bus.oBusy = active;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (bus.iValid && bus.iData == SYNC_BYTE)
          state_d = LEN;
      LEN:
        if (expire) state_d = IDLE;
        else if (bus.iValid)
          state_d = len_ok ? PAYLOAD : IDLE;
      PAYLOAD:
        if (expire) state_d = IDLE;
        else if (bus.iValid && cnt == len - 8'd1)
          state_d = CSUM;
      CSUM:
        if (expire) state_d = IDLE;
        else if (bus.iValid)
          state_d = csum_ok ? READY : IDLE;
      READY:
        if (last_rd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_len_d  = 1'b0;
    err_csum_d = 1'b0;
    err_to_d   = expire;
    drop_d     = 1'b0;
    unique case (1'b1)
      (state == LEN):
        err_len_d  = bus.iValid && !len_ok;
      (state == CSUM):
        err_csum_d = bus.iValid && !csum_ok;
      (state == READY):
        drop_d     = bus.iValid;
      default: ;
    endcase
  end

  // Payload buffer carries no reset; its contents only matter once framed.
  always_ff @(posedge clk) begin
    if (wr) mem[cnt[AW-1:0]] <= bus.iData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len             <= '0;
      sum             <= '0;
      cnt             <= '0;
      rdptr           <= '0;
      tcnt            <= '0;
      bus.oData       <= '0;
      bus.oDataValid  <= 1'b0;
      bus.oFrameReady <= 1'b0;
      bus.oLen        <= '0;
      bus.oErrLen     <= 1'b0;
      bus.oErrCsum    <= 1'b0;
      bus.oErrTimeout <= 1'b0;
      bus.oDrop       <= 1'b0;
    end else begin
      tcnt <= (active && !bus.iValid && !expire) ?
              tcnt + 1'b1 : '0;
      if (state == LEN && bus.iValid && len_ok) begin
        len <= bus.iData;
        sum <= bus.iData;
        cnt <= '0;
      end
      if (wr) begin
        sum <= sum + bus.iData;
        cnt <= cnt + 8'd1;
      end
      if (rd) begin
        bus.oData <= mem[rdptr[AW-1:0]];
        rdptr     <= last_rd ? 8'd0 : rdptr + 8'd1;
      end
      bus.oDataValid  <= rd;
      bus.oFrameReady <= (state_d == READY);
      bus.oLen        <= (state_d == READY) ? len : 8'd0;
      bus.oErrLen     <= err_len_d;
      bus.oErrCsum    <= err_csum_d;
      bus.oErrTimeout <= err_to_d;
      bus.oDrop       <= drop_d;
    end
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller placed directly behind the UART receiver. It consumes the receiver's byte strobe (oData/oValid) and sequences the byte stream into framed packets of the form SYNC, LEN, PAYLOAD[LEN], CSUM. It validates each frame, stores the payload in an internal buffer, and presents completed frames to the downstream consumer through a read handshake. It reports length, checksum and inter-byte timeout errors.

Parameters:
SYNC_BYTE, 8'hA5, start-of-frame marker.
MAX_LEN, 16, maximum payload length in bytes (1..255); sets the buffer depth.
TIMEOUT, 1000, maximum clk cycles allowed between bytes inside a frame (≥2).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
iData  input  8  received byte from the UART receiver.
iValid  input  1  one-cycle strobe; iData is valid in this cycle.
iRdEn  input  1  read request for the next payload byte (honoured only in READY).
oData  output  8  payload byte read out.
oDataValid  output  1  oData valid; high one cycle after an accepted iRdEn.
oFrameReady  output  1  a validated frame is held in the buffer.
oLen  output  8  payload length of the held frame; valid while oFrameReady=1.
oErrLen  output  1  one-cycle pulse: LEN was 0 or greater than MAX_LEN.
oErrCsum  output  1  one-cycle pulse: checksum mismatch.
oErrTimeout  output  1  one-cycle pulse: inter-byte timeout.
oDrop  output  1  one-cycle pulse: a byte arrived in READY and was discarded.
oBusy  output  1  high in LEN, PAYLOAD and CSUM.

Behaviour:
- Reset: state=IDLE. All outputs are 0, counters are 0, and the read pointer is 0. Buffer contents are don't-care. Reset in any state, including mid-frame or mid-readout, aborts with no error pulse.
- Checksum is the 8-bit modulo-256 sum of LEN and all payload bytes. SYNC is excluded.
- IDLE: on iValid with iData==SYNC_BYTE, go to LEN. Any other byte is ignored silently.
- LEN: on iValid:
  - If 1≤iData≤MAX_LEN: latch len=iData, sum=iData, cnt=0, go to PAYLOAD.
  - Otherwise: pulse oErrLen and go to IDLE.
- PAYLOAD: on iValid: buf[cnt]=iData, sum+=iData, cnt++. When the byte with cnt==len-1 is stored, go to CSUM.
- CSUM: on iValid:
  - If iData==sum: go to READY. oFrameReady=1 and oLen=len are registered, so both are high the cycle after the CSUM strobe.
  - Otherwise: pulse oErrCsum and go to IDLE.
- Error pulse timing: all error pulses are registered and assert the cycle after the offending strobe.
- READY:
  - iRdEn=1: oData<=buf[rdptr], oDataValid<=1 next cycle, rdptr++.
  - On the iRdEn that reads byte len-1: rdptr<=0 and state<=IDLE. oFrameReady falls in the same cycle that the last oDataValid is high.
  - iValid in READY: byte discarded, oDrop pulses. A SYNC_BYTE is discarded too.
- iRdEn outside READY: ignored, oDataValid stays 0. iRdEn held high reads one byte per cycle.
- Timeout counter:
  - Active only in LEN, PAYLOAD and CSUM. Cleared on entry to LEN and on every iValid.
  - Increments each cycle without iValid.
  - When it reaches TIMEOUT-1 with no iValid in that cycle: pulse oErrTimeout, go to IDLE.
  - iValid in the same cycle as expiry wins: the byte is processed and there is no timeout.
  - Counter width is clog2(TIMEOUT).
- Back-to-back frames: a SYNC is accepted on the first iValid after returning to IDLE. Bytes arriving while READY are lost (oDrop).

Test Plan:
- Good frame: A5 03 36 37 38 A8 at 160-clk byte spacing → oFrameReady=1, oLen=3. Three iRdEn give oData 36,37,38 with oDataValid. oFrameReady falls with the third oDataValid. No error pulses.
- Garbage then frame: 00 FF 36 A5 01 55 56 → leading bytes ignored, then a frame of len 1 with data 55. Bad checksum A5 02 10 20 31 → oErrCsum pulses once, back to IDLE, oFrameReady stays 0.
- Length errors: A5 00 → oErrLen. A5 11 (17 > MAX_LEN) → oErrLen. A5 10 followed by 16 bytes and a correct checksum → accepted, oLen=16.
- Timeout: A5 02 11 then silence → oErrTimeout pulses 1000 cycles after the 11 strobe. Repeat with a byte arriving exactly on the expiry cycle → no timeout, the byte is stored.
- Drop and readout stall: a frame is READY and unread, then iValid 42 → oDrop pulses and the buffer is unchanged. A subsequent readout returns the original bytes.
- Reset mid-operation: reset asserted during PAYLOAD and during READY readout → next cycle all outputs are 0 and state is IDLE. A new good frame is then received correctly.
